// File: rtl/axis_uart_rx_fifo_pkg.sv
// Shared types for the AXIS UART receiver: parity modes, FSM states, tuser bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    MARK0 = 3'd0,
    MARK1 = 3'd1,
    ODD   = 3'd2,
    EVEN  = 3'd3,
    NONE  = 3'd4
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } rx_state_e;

  localparam int TUSER_PERR = 0;
  localparam int TUSER_FERR = 1;
  localparam int TUSER_BRK  = 2;

  // Codes 4..7 all mean "no parity bit".
  function automatic parity_mode_e decode_parity(input logic [2:0] m);
    return m[2] ? NONE : parity_mode_e'(m);
  endfunction

endpackage

// File: rtl/axis_uart_rx_fifo_if.sv
// AXI-Stream beat carrying one received UART word plus its error flags on tuser.
interface axis_uart_rx_fifo_if #(parameter int DATA_MAX = 9);
  logic                tvalid;
  logic                tready;
  logic [DATA_MAX-1:0] tdata;
  logic [2:0]          tuser;

  modport master (output tvalid, tdata, tuser, input tready);
  modport slave  (input tvalid, tdata, tuser, output tready);
endinterface

// File: rtl/axis_uart_fifo.sv
// First-word-fall-through FIFO; a push while full is accepted only if a pop frees a slot.
module axis_uart_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             wr_en, rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      if (rd_en) rp <= rp + AW'(1);
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end
endmodule

// File: rtl/axis_uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, false-start rejection and break
// detection, feeding an AXIS master through a FWFT FIFO with per-word error flags.
module axis_uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_MAX    = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  axis_uart_rx_fifo_if.master           maxis,
  input  logic [DIV_W-1:0]              delitel,
  input  logic [3:0]                    data_bits,
  input  logic                          stop_bit_num,
  input  logic [2:0]                    parity_bit_mode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_rx_dropped,
  output logic                          err_rx,
  output logic                          err_stop
);
  localparam int W = DATA_MAX + 3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  rx_state_e             state;
  logic [DIV_W-1:0]      cnt, div_q, half, div_in;
  logic [3:0]            nb_q, nb_in, bit_idx;
  logic                  stop2_q;
  parity_mode_e          pm_q;
  logic [2:0]            samp;
  logic [DATA_MAX-1:0]   data_q;
  logic                  perr, ferr, pbit;
  logic                  three, samp_a, samp_b, samp_c, decide, bit_v;
  logic                  par_exp, frame_ferr, brk, push, pop, full, empty;
  logic [2:0]            user_w;
  logic [W-1:0]          wdata, rdata;

  assign div_in = (delitel < DIV_W'(2)) ? DIV_W'(2) : delitel;
  assign nb_in  = (data_bits < 4'd5) ? 4'd5 :
                  (data_bits > 4'(DATA_MAX)) ? 4'(DATA_MAX) : data_bits;

  // Three votes need div >= 4 so that half+2 still lands inside the bit period.
  assign three  = (div_q >= DIV_W'(4));
  assign half   = div_q >> 1;
  assign samp_a = three && (cnt == half - DIV_W'(1));
  assign samp_b = (cnt == half);
  assign samp_c = three && (cnt == half + DIV_W'(1));
  assign decide = (cnt == (three ? half + DIV_W'(2) : half + DIV_W'(1)));
  assign bit_v  = three ? ((samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]))
                        : samp[1];

  always_comb begin
    par_exp = 1'b0;
    case (pm_q)
      MARK1:   par_exp = 1'b1;
      ODD:     par_exp = ~^data_q;
      EVEN:    par_exp = ^data_q;
      default: par_exp = 1'b0;
    endcase
  end

  // Frame completes at the decision point of the last stop bit.
  assign push       = decide && ((state == STOP1 && !stop2_q) || state == STOP2);
  assign frame_ferr = ferr | ~bit_v;
  assign brk        = (data_q == '0) && !pbit && frame_ferr;

  always_comb begin
    user_w             = '0;
    user_w[TUSER_PERR] = perr;
    user_w[TUSER_FERR] = frame_ferr;
    user_w[TUSER_BRK]  = brk;
  end
  assign wdata = {user_w, data_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rxs_q          <= 1'b1;
      cnt            <= '0;
      samp           <= 3'b111;
      div_q          <= DIV_W'(2);
      nb_q           <= 4'd5;
      stop2_q        <= 1'b0;
      pm_q           <= NONE;
      bit_idx        <= '0;
      data_q         <= '0;
      perr           <= 1'b0;
      ferr           <= 1'b0;
      pbit           <= 1'b0;
      err_rx         <= 1'b0;
      err_stop       <= 1'b0;
      err_rx_dropped <= 1'b0;
    end else begin
      rxs_q          <= rxs;
      err_rx         <= push && perr;
      err_stop       <= push && frame_ferr;
      err_rx_dropped <= push && full && !pop;

      if (state != IDLE && state != WAIT_IDLE) begin
        cnt <= (cnt >= div_q) ? '0 : cnt + DIV_W'(1);
        if (samp_a) samp[0] <= rxs;
        if (samp_b) samp[1] <= rxs;
        if (samp_c) samp[2] <= rxs;
      end

      case (state)
        IDLE: if (rxs_q && !rxs) begin
          state   <= START;
          cnt     <= '0;
          div_q   <= div_in;
          nb_q    <= nb_in;
          stop2_q <= stop_bit_num;
          pm_q    <= decode_parity(parity_bit_mode);
          bit_idx <= '0;
          data_q  <= '0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
          pbit    <= 1'b0;
        end
        START: if (decide) state <= bit_v ? IDLE : DATA;
        DATA: if (decide) begin
          for (int i = 0; i < DATA_MAX; i++)
            if (bit_idx == 4'(i)) data_q[i] <= bit_v;
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == nb_q - 4'd1) state <= (pm_q == NONE) ? STOP1 : PARITY;
        end
        PARITY: if (decide) begin
          pbit  <= bit_v;
          perr  <= (bit_v != par_exp);
          state <= STOP1;
        end
        STOP1: if (decide) begin
          if (!bit_v) ferr <= 1'b1;
          if (stop2_q)         state <= STOP2;
          else if (frame_ferr) state <= WAIT_IDLE;
          else                 state <= IDLE;
        end
        STOP2: if (decide) state <= frame_ferr ? WAIT_IDLE : IDLE;
        WAIT_IDLE: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = maxis.tvalid && maxis.tready;

  axis_uart_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign maxis.tvalid = !empty;
  assign maxis.tdata  = rdata[DATA_MAX-1:0];
  assign maxis.tuser  = rdata[DATA_MAX +: 3];
endmodule
